// File: rtl/scan_fault_reporter_if.sv
// scan_fault_reporter_if: scan compare-stage inputs and UART/status outputs of the fault reporter
//   step_valid/step_idx/exp_vec/obs_vec : per-step compare results from the scan engine
//   tx_o/tx_busy/overflow/fault_cnt     : UART line and status back to the board
interface scan_fault_reporter_if #(
  parameter int N_PAIR = 86,
  parameter int IDX_W  = 7
);
  logic              step_valid;
  logic [IDX_W-1:0]  step_idx;
  logic [N_PAIR-1:0] exp_vec;
  logic [N_PAIR-1:0] obs_vec;
  logic              tx_o;
  logic              tx_busy;
  logic              overflow;
  logic [15:0]       fault_cnt;
  modport master (output step_valid, step_idx, exp_vec, obs_vec,
                  input  tx_o, tx_busy, overflow, fault_cnt);
  modport slave  (input  step_valid, step_idx, exp_vec, obs_vec,
                  output tx_o, tx_busy, overflow, fault_cnt);
endinterface

// File: rtl/scan_fault_reporter.sv
// scan_fault_reporter: condenses mismatching scan steps into 4-byte records, queues them and sends them over UART 8N1
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of scan_fault_reporter_if (step inputs, tx_o, tx_busy, overflow, fault_cnt)
//   SCAN_REPORT_DEDUP_EN : when defined, a hit repeating the last accepted {step_idx, first_idx, nbits} is not queued
module scan_fault_reporter #(
  parameter int N_PAIR   = 86,
  parameter int IDX_W    = 7,
  parameter int BAUD_DIV = 417,
  parameter int FIFO_AW  = 4
) (
  input logic clk,
  input logic reset,
  scan_fault_reporter_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int DIV_W = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam int TRI_W = 2 * IDX_W + 4;
  localparam int REC_W = TRI_W + 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [N_PAIR-1:0] diff;
  logic [IDX_W-1:0]  first_idx;
  logic [7:0]        pop_cnt;
  logic              s1_hit_q, s1_hit_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [IDX_W-1:0]  s1_first_q, s1_first_d;
  logic [3:0]        s1_nb_q, s1_nb_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [REC_W-1:0]  mem_d [DEPTH];
  logic [FIFO_AW:0]  wr_q, wr_d;
  logic [FIFO_AW:0]  rd_q, rd_d;
  logic [31:0]       sh_q, sh_d;
  logic [1:0]        byte_sel_q, byte_sel_d;
  logic [2:0]        bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              busy_q, busy_d;
  logic [TRI_W-1:0]  triple;
  logic [REC_W-1:0]  head;
  logic              full, empty, pop, dup, push_try, push, tick;
  // lowest set bit wins because the scan runs from the top down
  always_comb begin
    diff = bus.exp_vec ^ bus.obs_vec;
    first_idx = '0;
    pop_cnt = '0;
    for (int i = N_PAIR - 1; i >= 0; i--) begin
      if (diff[i]) first_idx = IDX_W'(i);
      pop_cnt = pop_cnt + 8'(diff[i]);
    end
  end
  always_comb begin
    s1_hit_d   = bus.step_valid && |diff;
    s1_idx_d   = bus.step_idx;
    s1_first_d = first_idx;
    s1_nb_d    = pop_cnt > 8'd15 ? 4'hF : pop_cnt[3:0];
  end
  assign triple = {s1_idx_q, s1_first_q, s1_nb_q};
  assign full   = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign empty  = wr_q == rd_q;
  assign pop    = state_q == LOAD;
  assign head   = mem_q[rd_q[FIFO_AW-1:0]];
  assign tick   = div_q == DIV_W'(BAUD_DIV - 1);
`ifdef SCAN_REPORT_DEDUP_EN
  logic             last_v_q, last_v_d;
  logic [TRI_W-1:0] last_q, last_d;
  assign dup = last_v_q && last_q == triple;
  always_comb begin
    last_v_d = last_v_q | push;
    last_d   = push ? triple : last_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_v_q <= 1'b0;
      last_q   <= '0;
    end else begin
      last_v_q <= last_v_d;
      last_q   <= last_d;
    end
`else
  assign dup = 1'b0;
`endif
  // a full FIFO still accepts when the transmitter frees the head slot in the same cycle
  assign push_try = s1_hit_q && !dup;
  assign push     = push_try && (!full || pop);
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[FIFO_AW-1:0]] = {pend_q, triple};
    wr_d   = wr_q + (FIFO_AW + 1)'(push);
    rd_d   = rd_q + (FIFO_AW + 1)'(pop);
    pend_d = push ? 1'b0 : push_try ? 1'b1 : pend_q;
    ovf_d  = ovf_q | (push_try & ~push);
    cnt_d  = s1_hit_q && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
  end
  // the whole record sits in one shift register, so the next byte follows the previous one's data bits
  always_comb begin
    div_d      = state_q inside {START, DATA, STOP} && !tick ? div_q + DIV_W'(1) : '0;
    bit_d      = state_q == DATA ? (tick ? bit_q + 3'd1 : bit_q) : '0;
    sh_d       = pop ? {head[REC_W-1], 3'b000, head[3:0], 8'(head[IDX_W+3 -: IDX_W]),
                        8'(head[TRI_W-1 -: IDX_W]), 8'hA5}
               : state_q == DATA && tick ? sh_q >> 1 : sh_q;
    byte_sel_d = pop ? 2'd0 : state_q == STOP && tick && byte_sel_q != 2'd3 ? byte_sel_q + 2'd1 : byte_sel_q;
    busy_d     = pop ? 1'b1 : state_q == STOP && tick && byte_sel_q == 2'd3 ? 1'b0 : busy_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = empty ? IDLE : LOAD;
      LOAD:    state_d = START;
      START:   state_d = tick ? DATA : START;
      DATA:    state_d = tick && bit_q == 3'd7 ? STOP : DATA;
      STOP:    state_d = tick ? (byte_sel_q == 2'd3 ? IDLE : START) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.tx_o = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_hit_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_first_q <= '0;
      s1_nb_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      sh_q       <= '0;
      byte_sel_q <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      s1_hit_q   <= s1_hit_d;
      s1_idx_q   <= s1_idx_d;
      s1_first_q <= s1_first_d;
      s1_nb_q    <= s1_nb_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      sh_q       <= sh_d;
      byte_sel_q <= byte_sel_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      busy_q     <= busy_d;
    end
  assign bus.tx_busy   = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.fault_cnt = cnt_q;
endmodule
